// File: rtl/axis_ingress_dest_filter.sv
// rtl/axis_ingress_dest_filter.sv - per-packet TDEST filter and length limiter with a 2-entry registered output buffer
module axis_ingress_dest_filter #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int MAX_PKT_BEATS   = 190,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [AXIS_BUS_WIDTH-1:0]       axis_s_tdata,
  input  logic [AXIS_DEST_WIDTH-1:0]      axis_s_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]     axis_s_tkeep,
  input  logic                            axis_s_tlast,
  input  logic                            axis_s_tvalid,
  output logic                            axis_s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]       axis_m_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]      axis_m_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]     axis_m_tkeep,
  output logic                            axis_m_tlast,
  output logic                            axis_m_tvalid,
  input  logic                            axis_m_tready,
  input  logic                            filter_en,
  input  logic [2**AXIS_DEST_WIDTH-1:0]   dest_allow_mask,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic [CNT_WIDTH-1:0]            trunc_count
);

  localparam int KW  = AXIS_BUS_WIDTH / 8;
  localparam int EW  = AXIS_BUS_WIDTH + KW + AXIS_DEST_WIDTH + 1;
  localparam int BCW = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [BCW-1:0] MAX_B = BCW'(MAX_PKT_BEATS);
  localparam bit ONE_BEAT_MAX = (MAX_PKT_BEATS == 1);

  typedef enum logic [1:0] {ST_SOP, ST_PASS, ST_DROP} state_t;

  state_t                     state, state_nxt;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_nxt, push_dest;
  logic [BCW-1:0]             beat_cnt, beat_cnt_nxt, beat_cnt_inc;
  logic                       s_hs, pop, push, push_last, drop_inc, trunc_inc, allowed;
  logic [EW-1:0]              push_ent, ent0, ent1;
  logic [1:0]                 occ, occ_nxt;

  assign s_hs         = axis_s_tvalid && axis_s_tready;
  assign pop          = axis_m_tvalid && axis_m_tready;
  assign allowed      = !filter_en || dest_allow_mask[axis_s_tdest];
  assign beat_cnt_inc = beat_cnt + BCW'(1);
  assign push_ent     = {axis_s_tdata, axis_s_tkeep, push_dest, push_last};
  assign occ_nxt      = occ + {1'b0, push} - {1'b0, pop};

  assign {axis_m_tdata, axis_m_tkeep, axis_m_tdest, axis_m_tlast} = ent0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_SOP;
      dest_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dest_q   <= dest_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    dest_nxt     = dest_q;
    beat_cnt_nxt = beat_cnt;
    push         = 1'b0;
    push_last    = axis_s_tlast;
    push_dest    = dest_q;
    drop_inc     = 1'b0;
    trunc_inc    = 1'b0;
    if (s_hs) begin
      case (state)
        ST_SOP: begin
          if (allowed) begin
            push         = 1'b1;
            push_dest    = axis_s_tdest;
            dest_nxt     = axis_s_tdest;
            beat_cnt_nxt = BCW'(1);
            if (!axis_s_tlast) begin
              if (ONE_BEAT_MAX) begin
                push_last = 1'b1;
                trunc_inc = 1'b1;
                state_nxt = ST_DROP;
              end else begin
                state_nxt = ST_PASS;
              end
            end
          end else begin
            drop_inc = 1'b1;
            if (!axis_s_tlast) state_nxt = ST_DROP;
          end
        end
        ST_PASS: begin
          push         = 1'b1;
          beat_cnt_nxt = beat_cnt_inc;
          if (axis_s_tlast) begin
            state_nxt = ST_SOP;
          end else if (beat_cnt_inc == MAX_B) begin
            // Limit reached mid-packet: close it here and swallow the tail.
            push_last = 1'b1;
            trunc_inc = 1'b1;
            state_nxt = ST_DROP;
          end
        end
        ST_DROP: begin
          if (axis_s_tlast) state_nxt = ST_SOP;
        end
        default: state_nxt = ST_SOP;
      endcase
    end
  end

  // Ready only looks at our own next occupancy, so it never chains from axis_m_tready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ           <= 2'd0;
      ent0          <= '0;
      ent1          <= '0;
      axis_m_tvalid <= 1'b0;
      axis_s_tready <= 1'b0;
    end else begin
      occ           <= occ_nxt;
      axis_m_tvalid <= (occ_nxt != 2'd0);
      axis_s_tready <= (state_nxt == ST_DROP) || (occ_nxt <= 2'd1);
      if (pop) begin
        if (occ == 2'd2) begin
          ent0 <= ent1;
          if (push) ent1 <= push_ent;
        end else if (push) begin
          ent0 <= push_ent;
        end
      end else if (push) begin
        if (occ == 2'd0) ent0 <= push_ent;
        else             ent1 <= push_ent;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (drop_inc && (drop_count != '1))   drop_count  <= drop_count + CNT_WIDTH'(1);
      if (trunc_inc && (trunc_count != '1)) trunc_count <= trunc_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_ingress_dest_filter.sv
// tb/tb_axis_ingress_dest_filter.sv - randomized scoreboard bench for axis_ingress_dest_filter
module tb_axis_ingress_dest_filter;

  localparam int W    = 64;
  localparam int DW   = 4;
  localparam int KW   = W / 8;
  localparam int MAXB = 4;
  localparam int CW   = 2;
  localparam int CMAX = 2**CW - 1;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic [DW-1:0] dest;
    logic          last;
  } beat_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [W-1:0]      s_tdata = '0;
  logic [DW-1:0]     s_tdest = '0;
  logic [KW-1:0]     s_tkeep = '0;
  logic              s_tlast = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [W-1:0]      m_tdata;
  logic [DW-1:0]     m_tdest;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              filter_en = 1'b0;
  logic [2**DW-1:0]  dest_allow_mask = '0;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     trunc_count;

  axis_ingress_dest_filter #(
    .AXIS_BUS_WIDTH (W),
    .AXIS_DEST_WIDTH(DW),
    .MAX_PKT_BEATS  (MAXB),
    .CNT_WIDTH      (CW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .axis_s_tdata   (s_tdata),
    .axis_s_tdest   (s_tdest),
    .axis_s_tkeep   (s_tkeep),
    .axis_s_tlast   (s_tlast),
    .axis_s_tvalid  (s_tvalid),
    .axis_s_tready  (s_tready),
    .axis_m_tdata   (m_tdata),
    .axis_m_tdest   (m_tdest),
    .axis_m_tkeep   (m_tkeep),
    .axis_m_tlast   (m_tlast),
    .axis_m_tvalid  (m_tvalid),
    .axis_m_tready  (m_tready),
    .filter_en      (filter_en),
    .dest_allow_mask(dest_allow_mask),
    .drop_count     (drop_count),
    .trunc_count    (trunc_count)
  );

  always #5 aclk = ~aclk;

  beat_t tx_q[$];
  beat_t exp_q[$];
  beat_t stall_b;
  int    n_total = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    last_in_cyc = 0;
  int    acc_cnt = 0;
  int    valid_pct = 100;
  int    rdy_pct = 100;
  int    exp_drop = 0;
  int    exp_trunc = 0;
  bit    at_sop = 1'b1;
  bit    chk_lat = 1'b0;
  bit    chg_mask = 1'b0;
  bit    stall_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int len, input logic [DW-1:0] dest, input bit rnd_dest);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.dest = (i == 0 || !rnd_dest) ? dest : DW'($urandom);
      b.last = (i == len - 1);
      tx_q.push_back(b);
    end
  endtask

  // Whole-packet view: decided from the first beat and the packet length.
  task automatic model_sop();
    int len;
    int n;
    bit ok;
    len = 0;
    while (len < tx_q.size()) begin
      len++;
      if (tx_q[len-1].last) break;
    end
    ok = !filter_en || dest_allow_mask[tx_q[0].dest];
    if (ok) begin
      n = (len > MAXB) ? MAXB : len;
      for (int i = 0; i < n; i++) begin
        beat_t e;
        e      = tx_q[i];
        e.dest = tx_q[0].dest;
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
      if (len > MAXB && exp_trunc < CMAX) exp_trunc++;
    end else if (exp_drop < CMAX) begin
      exp_drop++;
    end
  endtask

  task automatic step();
    bit    in_hs;
    bit    out_hs;
    beat_t e;
    beat_t b;
    @(negedge aclk);
    in_hs  = s_tvalid && s_tready;
    out_hs = m_tvalid && m_tready;
    if (stall_prev) begin
      chk("stall_valid", 64'(m_tvalid), 64'(1));
      chk("stall_data", m_tdata, stall_b.data);
      chk("stall_side", 64'({m_tdest, m_tkeep, m_tlast}),
          64'({stall_b.dest, stall_b.keep, stall_b.last}));
    end
    stall_prev   = m_tvalid && !m_tready;
    stall_b.data = m_tdata;
    stall_b.keep = m_tkeep;
    stall_b.dest = m_tdest;
    stall_b.last = m_tlast;
    if (out_hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(m_tvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_tdata, e.data);
        chk("out_keep", 64'(m_tkeep), 64'(e.keep));
        chk("out_dest", 64'(m_tdest), 64'(e.dest));
        chk("out_last", 64'(m_tlast), 64'(e.last));
        if (chk_lat) chk("latency", 64'(last_in_cyc), 64'(cyc - 1));
      end
    end
    if (in_hs) begin
      if (at_sop) model_sop();
      b           = tx_q.pop_front();
      at_sop      = b.last;
      last_in_cyc = cyc;
      acc_cnt++;
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (!s_tvalid || in_hs) begin
      if (tx_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        s_tvalid = 1'b1;
        s_tdata  = tx_q[0].data;
        s_tkeep  = tx_q[0].keep;
        s_tdest  = tx_q[0].dest;
        s_tlast  = tx_q[0].last;
      end else begin
        s_tvalid = 1'b0;
      end
    end
    m_tready = (int'($urandom_range(99)) < rdy_pct);
    if (chg_mask && $urandom_range(99) < 20) begin
      filter_en       = 1'($urandom);
      dest_allow_mask = (2**DW)'($urandom);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((tx_q.size() > 0 || s_tvalid || exp_q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    repeat (3) step();
    chk({tag, "_drained"}, 64'(exp_q.size() + tx_q.size()), 64'(0));
    chk({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
    chk({tag, "_trunc"}, 64'(trunc_count), 64'(exp_trunc));
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    s_tvalid   = 1'b0;
    tx_q.delete();
    exp_q.delete();
    at_sop     = 1'b1;
    stall_prev = 1'b0;
    exp_drop   = 0;
    exp_trunc  = 0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tdata", m_tdata, 64'(0));
    chk("rst_m_side", 64'({m_tdest, m_tkeep, m_tlast}), 64'(0));
    chk("rst_counts", 64'({drop_count, trunc_count}), 64'(0));
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("rst_release_tready", 64'(s_tready), 64'(1));
  endtask

  initial begin
    int idx;
    do_reset();

    filter_en = 1'b0;
    chk_lat   = 1'b1;
    m_tready  = 1'b1;
    add_pkt(4, 4'd3, 1'b0);
    drain("pass");

    filter_en       = 1'b1;
    dest_allow_mask = 16'h0001;
    add_pkt(3, 4'd2, 1'b0);
    add_pkt(2, 4'd0, 1'b0);
    drain("dest_drop");

    filter_en = 1'b0;
    add_pkt(7, 4'd5, 1'b0);
    drain("trunc7");
    add_pkt(4, 4'd6, 1'b0);
    drain("trunc4");

    filter_en       = 1'b1;
    dest_allow_mask = 16'h0002;
    add_pkt(3, 4'd1, 1'b0);
    idx = tx_q.size() - 2;
    tx_q[idx].dest = 4'd5;
    idx = tx_q.size() - 1;
    tx_q[idx].dest = 4'd7;
    drain("pinned");

    do_reset();
    chk_lat   = 1'b0;
    filter_en = 1'b0;
    m_tready  = 1'b0;
    rdy_pct   = 0;
    add_pkt(6, 4'd4, 1'b0);
    acc_cnt = 0;
    repeat (5) step();
    chk("bp_accepted", 64'(acc_cnt), 64'(2));
    chk("bp_s_tready", 64'(s_tready), 64'(0));
    chk("bp_m_tvalid", 64'(m_tvalid), 64'(1));
    rdy_pct = 100;
    drain("bp");

    for (int r = 0; r < 25; r++) begin
      do_reset();
      valid_pct       = int'($urandom_range(100, 30));
      rdy_pct         = int'($urandom_range(100, 30));
      m_tready        = 1'b1;
      chg_mask        = 1'b1;
      filter_en       = 1'($urandom);
      dest_allow_mask = (2**DW)'($urandom);
      for (int p = 0; p < 6; p++) add_pkt(int'($urandom_range(8, 1)), DW'($urandom), 1'b1);
      drain("rand");
    end
    chg_mask  = 1'b0;
    valid_pct = 100;

    filter_en = 1'b0;
    m_tready  = 1'b0;
    rdy_pct   = 0;
    add_pkt(8, 4'd2, 1'b0);
    repeat (4) step();
    areset = 1'b1;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("midrst_m_tdata", m_tdata, 64'(0));
    chk("midrst_s_tready", 64'(s_tready), 64'(0));
    do_reset();
    rdy_pct  = 100;
    m_tready = 1'b1;
    chk_lat  = 1'b1;
    add_pkt(2, 4'd9, 1'b0);
    drain("post_rst");

    filter_en       = 1'b1;
    dest_allow_mask = 16'h0001;
    for (int p = 0; p < 5; p++) add_pkt(2, 4'd2, 1'b0);
    drain("sat");
    chk("sat_drop_value", 64'(drop_count), 64'(3));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
